// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// the state encoding, opcode and ALU function codes, the strobe bundle,
// and helpers that classify an opcode and pick its ALU function.
package cpu_ctrl_pkg;

  localparam int OP_W  = 5;
  localparam int ALU_W = 4;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3, T4, T5, T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_BIN, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_UNKNOWN
  } op_class_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11001;

  localparam logic [ALU_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SHR = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SHL = 4'd6;
  localparam logic [ALU_W-1:0] ALU_ROR = 4'd7;
  localparam logic [ALU_W-1:0] ALU_ROL = 4'd8;
  localparam logic [ALU_W-1:0] ALU_MUL = 4'd9;
  localparam logic [ALU_W-1:0] ALU_DIV = 4'd10;
  localparam logic [ALU_W-1:0] ALU_NEG = 4'd11;
  localparam logic [ALU_W-1:0] ALU_NOT = 4'd12;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic z_low_out;
    logic z_high_out;
    logic lo_in;
    logic hi_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

  // Which execute sequence an opcode follows.
  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:   return CLS_BIN;
      OP_MUL, OP_DIV:                  return CLS_MULDIV;
      OP_NEG, OP_NOT:                  return CLS_UNARY;
      OP_NOP:                          return CLS_NOP;
      OP_HALT:                         return CLS_HALT;
      default:                         return CLS_UNKNOWN;
    endcase
  endfunction

  // ALU function for an opcode; non-ALU opcodes map to ALU_NOP.
  function automatic logic [ALU_W-1:0] alu_select(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps present state (and, in execute
// states, the opcode) onto the datapath control strobes and ALU select.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t              state,
  input  logic [OP_W-1:0]     opcode,
  output strobes_t            strobes,
  output logic [ALU_W-1:0]    alu_op
);

  op_class_t cls;
  assign cls = classify(opcode);

  // Moore decode: every strobe defaults low, ALU select stays NOP except in the evaluate state
  always_comb begin
    strobes = '0;
    alu_op  = ALU_NOP;
    case (state)
      T0: begin
        strobes.pc_out = 1'b1;
        strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1;
        strobes.z_in   = 1'b1;
      end
      T1: begin
        strobes.z_low_out = 1'b1;
        strobes.pc_in     = 1'b1;
        strobes.read      = 1'b1;
        strobes.mdr_in    = 1'b1;
      end
      T2: begin
        strobes.mdr_out = 1'b1;
        strobes.ir_in   = 1'b1;
      end
      T3: begin
        if (cls == CLS_BIN || cls == CLS_MULDIV) begin
          strobes.grb   = 1'b1;
          strobes.r_out = 1'b1;
          strobes.y_in  = 1'b1;
        end else if (cls == CLS_UNARY) begin
          strobes.grb   = 1'b1;
          strobes.r_out = 1'b1;
          strobes.z_in  = 1'b1;
          alu_op        = alu_select(opcode);
        end
      end
      T4: begin
        if (cls == CLS_BIN || cls == CLS_MULDIV) begin
          strobes.grc   = 1'b1;
          strobes.r_out = 1'b1;
          strobes.z_in  = 1'b1;
          alu_op        = alu_select(opcode);
        end else if (cls == CLS_UNARY) begin
          strobes.z_low_out = 1'b1;
          strobes.gra       = 1'b1;
          strobes.r_in      = 1'b1;
        end
      end
      T5: begin
        if (cls == CLS_BIN) begin
          strobes.z_low_out = 1'b1;
          strobes.gra       = 1'b1;
          strobes.r_in      = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          strobes.z_low_out = 1'b1;
          strobes.lo_in     = 1'b1;
        end
      end
      T6: begin
        if (cls == CLS_MULDIV) begin
          strobes.z_high_out = 1'b1;
          strobes.hi_in      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: fetches an
// instruction with a memory handshake, then steps the execute states for
// ALU-class opcodes. Optional build macro CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
// makes unknown opcodes halt with a sticky illegal_op flag instead of
// running as NOP.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            LOin,
  output logic            HIin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal_op
);

  state_t          state_q, state_d;
  logic [OPW-1:0]  opcode;
  op_class_t       cls;
  strobes_t        strobes;
  logic            unused_ir;

  assign opcode    = ir[31:27];
  assign cls       = classify(opcode);
  assign unused_ir = ^ir[26:0];

  // State register; clear forces an immediate return to S_RST
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next state: fetch with memory wait in T1, then branch on opcode class at T3
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = T0;
      T0:    state_d = T1;
      T1:    state_d = mem_ready ? T2 : T1;
      T2:    state_d = T3;
      T3: begin
        case (cls)
          CLS_BIN, CLS_MULDIV, CLS_UNARY: state_d = T4;
          CLS_HALT:                       state_d = S_HALT;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
          CLS_UNKNOWN:                    state_d = S_HALT;
`endif
          default:                        state_d = T0;
        endcase
      end
      T4:     state_d = (cls == CLS_BIN || cls == CLS_MULDIV) ? T5 : T0;
      T5:     state_d = (cls == CLS_MULDIV) ? T6 : T0;
      T6:     state_d = T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky trap flag, set when an unknown opcode reaches T3
  always_comb begin
    illegal_d = illegal_q;
    if (state_q == T3 && cls == CLS_UNKNOWN) illegal_d = 1'b1;
  end

  // Flag register; only clear releases it
  always_ff @(posedge clock or posedge clear) begin
    if (clear) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  ctrl_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .strobes (strobes),
    .alu_op  (alu_op)
  );

  assign run      = (state_q != S_RST) && (state_q != S_HALT);
  assign PCout    = strobes.pc_out;
  assign PCin     = strobes.pc_in;
  assign IncPC    = strobes.inc_pc;
  assign MARin    = strobes.mar_in;
  assign Read     = strobes.read;
  assign MDRin    = strobes.mdr_in;
  assign MDRout   = strobes.mdr_out;
  assign IRin     = strobes.ir_in;
  assign Yin      = strobes.y_in;
  assign Zin      = strobes.z_in;
  assign Zlowout  = strobes.z_low_out;
  assign Zhighout = strobes.z_high_out;
  assign LOin     = strobes.lo_in;
  assign HIin     = strobes.hi_in;
  assign Gra      = strobes.gra;
  assign Grb      = strobes.grb;
  assign Grc      = strobes.grc;
  assign Rin      = strobes.r_in;
  assign Rout     = strobes.r_out;

  // At most one bus driver is enabled in any state
  bus_exclusive: assert property (@(posedge clock) disable iff (clear)
    $onehot0({PCout, MDRout, Zlowout, Zhighout, Rout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instructions from the
// test plan followed by random opcodes and memory waits, each checked cycle
// by cycle against a per-instruction expected strobe schedule.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [3:0] alu_op;
  logic run, illegal_op;

  int checks;
  int fails;
  logic exp_illegal;

  // Bit masks for the observed strobe vector, PCout in the MSB down to Rout
  localparam logic [18:0] M_PCOUT  = 19'd1 << 18;
  localparam logic [18:0] M_PCIN   = 19'd1 << 17;
  localparam logic [18:0] M_INCPC  = 19'd1 << 16;
  localparam logic [18:0] M_MARIN  = 19'd1 << 15;
  localparam logic [18:0] M_READ   = 19'd1 << 14;
  localparam logic [18:0] M_MDRIN  = 19'd1 << 13;
  localparam logic [18:0] M_MDROUT = 19'd1 << 12;
  localparam logic [18:0] M_IRIN   = 19'd1 << 11;
  localparam logic [18:0] M_YIN    = 19'd1 << 10;
  localparam logic [18:0] M_ZIN    = 19'd1 << 9;
  localparam logic [18:0] M_ZLO    = 19'd1 << 8;
  localparam logic [18:0] M_ZHI    = 19'd1 << 7;
  localparam logic [18:0] M_LOIN   = 19'd1 << 6;
  localparam logic [18:0] M_HIIN   = 19'd1 << 5;
  localparam logic [18:0] M_GRA    = 19'd1 << 4;
  localparam logic [18:0] M_GRB    = 19'd1 << 3;
  localparam logic [18:0] M_GRC    = 19'd1 << 2;
  localparam logic [18:0] M_RIN    = 19'd1 << 1;
  localparam logic [18:0] M_ROUT   = 19'd1 << 0;

  typedef struct {
    logic [18:0] s;
    logic [3:0]  alu;
    logic        run;
    logic        is_t1;
    logic        t1_last;
  } step_t;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run),
    .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction kind: 0 binary, 1 mul/div, 2 unary, 3 nop, 4 halt, 5 unknown
  function automatic int kindOf(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: return 0;
      5'b01110, 5'b01111:                     return 1;
      5'b10000, 5'b10001:                     return 2;
      5'b11000:                               return 3;
      5'b11001:                               return 4;
      default:                                return 5;
    endcase
  endfunction

  function automatic logic [3:0] aluOf(input logic [4:0] op);
    case (op)
      5'b00011: return 4'd1;
      5'b00100: return 4'd2;
      5'b01001: return 4'd3;
      5'b01010: return 4'd4;
      5'b00101: return 4'd5;
      5'b00110: return 4'd6;
      5'b00111: return 4'd7;
      5'b01000: return 4'd8;
      5'b01110: return 4'd9;
      5'b01111: return 4'd10;
      5'b10000: return 4'd11;
      5'b10001: return 4'd12;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic step_t mkStep(input logic [18:0] s, input logic [3:0] alu,
                                   input logic is_t1, input logic t1_last);
    step_t st;
    st.s = s; st.alu = alu; st.run = 1'b1;
    st.is_t1 = is_t1; st.t1_last = t1_last;
    return st;
  endfunction

  function automatic logic trapBuild();
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Compare every output against the expectation and count the result
  task automatic checkOutput(input string tag, input logic [18:0] exp_s,
                             input logic [3:0] exp_alu, input logic exp_run,
                             input logic exp_ill);
    logic [24:0] obs, expv;
    obs  = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
            Yin, Zin, Zlowout, Zhighout, LOin, HIin,
            Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal_op};
    expv = {exp_s, exp_alu, exp_run, exp_ill};
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Assert clear, check the reset state, release mid-cycle and land on T0
  task automatic doReset();
    clear = 1'b1;
    mem_ready = 1'b0;
    exp_illegal = 1'b0;
    #1 checkOutput("reset_held", '0, 4'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    clear = 1'b0;
    #1 checkOutput("reset_released", '0, 4'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
  endtask

  // Run one instruction from T0, checking every cycle against its schedule
  task automatic applyStimulus(input logic [31:0] instr, input int wait_cycles,
                               input int abort_at, input int halt_cycles);
    step_t steps[$];
    logic [4:0] op;
    int kind;
    logic halts;
    op   = instr[31:27];
    kind = kindOf(op);
    halts = (kind == 4) || (kind == 5 && trapBuild());

    steps.push_back(mkStep(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0, 1'b0));
    for (int w = 0; w <= wait_cycles; w++)
      steps.push_back(mkStep(M_ZLO | M_PCIN | M_READ | M_MDRIN, 4'd0, 1'b1, w == wait_cycles));
    steps.push_back(mkStep(M_MDROUT | M_IRIN, 4'd0, 1'b0, 1'b0));
    case (kind)
      0: begin
        steps.push_back(mkStep(M_GRB | M_ROUT | M_YIN, 4'd0, 1'b0, 1'b0));
        steps.push_back(mkStep(M_GRC | M_ROUT | M_ZIN, aluOf(op), 1'b0, 1'b0));
        steps.push_back(mkStep(M_ZLO | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0));
      end
      1: begin
        steps.push_back(mkStep(M_GRB | M_ROUT | M_YIN, 4'd0, 1'b0, 1'b0));
        steps.push_back(mkStep(M_GRC | M_ROUT | M_ZIN, aluOf(op), 1'b0, 1'b0));
        steps.push_back(mkStep(M_ZLO | M_LOIN, 4'd0, 1'b0, 1'b0));
        steps.push_back(mkStep(M_ZHI | M_HIIN, 4'd0, 1'b0, 1'b0));
      end
      2: begin
        steps.push_back(mkStep(M_GRB | M_ROUT | M_ZIN, aluOf(op), 1'b0, 1'b0));
        steps.push_back(mkStep(M_ZLO | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0));
      end
      default: steps.push_back(mkStep('0, 4'd0, 1'b0, 1'b0));
    endcase

    for (int i = 0; i < steps.size(); i++) begin
      mem_ready = steps[i].is_t1 ? steps[i].t1_last : 1'($urandom);
      ir = (i < wait_cycles + 2) ? $urandom : instr;
      #1 checkOutput($sformatf("op%05b_step%0d", op, i), steps[i].s,
                     steps[i].alu, steps[i].run, exp_illegal);
      if (i == abort_at) begin
        #2 clear = 1'b1;
        exp_illegal = 1'b0;
        #1 checkOutput("async_clear", '0, 4'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        clear = 1'b0;
        #1 checkOutput("after_clear_srst", '0, 4'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end

    if (halts) begin
      if (kind == 5) exp_illegal = 1'b1;
      for (int h = 0; h < halt_cycles; h++) begin
        mem_ready = 1'($urandom);
        ir = $urandom;
        #1 checkOutput($sformatf("halted_%0d", h), '0, 4'd0, 1'b0, exp_illegal);
        @(posedge clock); #1;
      end
      doReset();
    end
  endtask

  initial begin
    logic [4:0] pool [16];
    logic [4:0] op;
    checks = 0;
    fails = 0;
    exp_illegal = 1'b0;
    clear = 1'b0;
    ir = 32'h0;
    mem_ready = 1'b0;
    pool = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
             5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001,
             5'b11000, 5'b11001, 5'b11111, 5'b00000};

    #2 doReset();
    $display("[TB] directed instructions");
    applyStimulus(32'h4A000000, 0, -1, 0);
    applyStimulus(32'h18A40000, 3, -1, 0);
    applyStimulus(32'h70000000, 1, -1, 0);
    applyStimulus(32'h80000000, 0, -1, 0);
    applyStimulus(32'h18000000, 1, 5, 0);
    applyStimulus(32'hC0000000, 0, -1, 0);
    applyStimulus(32'hF8000000, 2, -1, 5);
    applyStimulus(32'hC8000000, 0, -1, 20);

    $display("[TB] random instructions");
    for (int n = 0; n < 40; n++) begin
      op = pool[$urandom_range(0, 15)];
      applyStimulus({op, 27'($urandom)}, int'($urandom_range(0, 3)), -1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
